// File: rtl/stdp_learn.sv
// Pair-based STDP synapse: nearest-neighbour pre/post timers drive a saturating 8-bit weight.
// Depression (pre-after-post) is compiled in only when STDP_LTD_EN is defined.
module stdp_learn #(
  parameter int unsigned WINDOW = 15,
  parameter logic [7:0]  W_INIT = 8'd128,
  parameter logic [7:0]  A_LTP  = 8'd16,
  parameter logic [7:0]  A_LTD  = 8'd16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pre_spike,
  input  logic       post_spike,
  output logic [7:0] weight,
  output logic       update_w_flag,
  output logic [4:0] time_diff,
  output logic       ltp
);

  logic [4:0] r_pre_t, r_post_t;
  logic       r_pre_v, r_post_v;

  logic       w_pre_ok, w_post_ok;
  logic       w_pot, w_dep;
  logic [7:0] w_ltp_step;
  logic [8:0] w_sum;
  logic [7:0] w_pot_w;
  logic [7:0] w_dep_w;

  // A timer that has just reached WINDOW+1 is already expired, before its valid bit drops.
  assign w_pre_ok  = r_pre_v  && (r_pre_t  <= 5'(WINDOW));
  assign w_post_ok = r_post_v && (r_post_t <= 5'(WINDOW));

  assign w_pot      = post_spike && !pre_spike && w_pre_ok;
  assign w_ltp_step = A_LTP >> r_pre_t[4:2];
  assign w_sum      = {1'b0, weight} + {1'b0, w_ltp_step};
  assign w_pot_w    = w_sum[8] ? 8'hFF : w_sum[7:0];

`ifdef STDP_LTD_EN
  logic [7:0] w_ltd_step;
  logic [8:0] w_diff;
  assign w_dep      = pre_spike && !post_spike && w_post_ok;
  assign w_ltd_step = A_LTD >> r_post_t[4:2];
  assign w_diff     = {1'b0, weight} - {1'b0, w_ltd_step};
  assign w_dep_w    = w_diff[8] ? 8'h00 : w_diff[7:0];
`else
  assign w_dep   = 1'b0;
  assign w_dep_w = weight;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre_t       <= '0;
      r_post_t      <= '0;
      r_pre_v       <= 1'b0;
      r_post_v      <= 1'b0;
      weight        <= W_INIT;
      update_w_flag <= 1'b0;
      time_diff     <= '0;
      ltp           <= 1'b0;
    end else begin
      if (pre_spike) begin
        r_pre_t <= 5'd1;
        r_pre_v <= 1'b1;
      end else if (w_pot) begin
        r_pre_v <= 1'b0;
      end else if (r_pre_v) begin
        if (r_pre_t > 5'(WINDOW)) r_pre_v <= 1'b0;
        else                      r_pre_t <= r_pre_t + 5'd1;
      end

      if (post_spike) begin
        r_post_t <= 5'd1;
        r_post_v <= 1'b1;
      end else if (w_dep) begin
        r_post_v <= 1'b0;
      end else if (r_post_v) begin
        if (r_post_t > 5'(WINDOW)) r_post_v <= 1'b0;
        else                       r_post_t <= r_post_t + 5'd1;
      end

      update_w_flag <= w_pot || w_dep;
      if (w_pot) begin
        weight    <= w_pot_w;
        time_diff <= r_pre_t;
        ltp       <= 1'b1;
      end else if (w_dep) begin
        weight    <= w_dep_w;
        time_diff <= r_post_t;
        ltp       <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stdp_learn.sv
// Self-checking bench for stdp_learn: directed scenarios plus randomized spikes vs a spike-time model.
module tb_stdp_learn;

  localparam int WIN  = 15;
  localparam int WI   = 128;
  localparam int ALTP = 16;
  localparam int ALTD = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pre_spike = 1'b0;
  logic       post_spike = 1'b0;
  logic [7:0] weight;
  logic       update_w_flag;
  logic [4:0] time_diff;
  logic       ltp;

  int checks = 0;
  int errors = 0;

  // Model state: absolute spike times, not timers.
  int   m_now = 0;
  int   m_w = WI;
  int   m_td = 0;
  logic m_flag = 1'b0;
  logic m_ltp = 1'b0;
  int   m_pre_last = 0, m_post_last = 0;
  logic m_pre_av = 1'b0, m_post_av = 1'b0;

  logic [14:0] got, exp;

  stdp_learn #(
    .WINDOW(WIN),
    .W_INIT(8'(WI)),
    .A_LTP (8'(ALTP)),
    .A_LTD (8'(ALTD))
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pre_spike    (pre_spike),
    .post_spike   (post_spike),
    .weight       (weight),
    .update_w_flag(update_w_flag),
    .time_diff    (time_diff),
    .ltp          (ltp)
  );

  always #5 clk = ~clk;

  task automatic model_edge(input logic p, input logic q, input logic r);
    int dt;
    if (r) begin
      m_w = WI; m_flag = 1'b0; m_td = 0; m_ltp = 1'b0;
      m_pre_av = 1'b0; m_post_av = 1'b0;
    end else begin
      m_flag = 1'b0;
      if (p && q) begin
        m_pre_last = m_now; m_post_last = m_now;
        m_pre_av = 1'b1; m_post_av = 1'b1;
      end else if (q) begin
        if (m_pre_av && (m_now - m_pre_last) <= WIN) begin
          dt = m_now - m_pre_last;
          m_w = m_w + (ALTP >> (dt / 4));
          if (m_w > 255) m_w = 255;
          m_td = dt; m_ltp = 1'b1; m_flag = 1'b1; m_pre_av = 1'b0;
        end
        m_post_last = m_now; m_post_av = 1'b1;
      end else if (p) begin
`ifdef STDP_LTD_EN
        if (m_post_av && (m_now - m_post_last) <= WIN) begin
          dt = m_now - m_post_last;
          m_w = m_w - (ALTD >> (dt / 4));
          if (m_w < 0) m_w = 0;
          m_td = dt; m_ltp = 1'b0; m_flag = 1'b1; m_post_av = 1'b0;
        end
`endif
        m_pre_last = m_now; m_pre_av = 1'b1;
      end
    end
    m_now++;
    exp = {8'(m_w), m_flag, 5'(m_td), m_ltp};
  endtask

  // One clock: drive inputs, advance the model on the edge, sample 1 time unit later.
  task automatic step(input logic p, input logic q, input logic r);
    pre_spike = p; post_spike = q; rst = r;
    @(posedge clk);
    model_edge(p, q, r);
    #1;
    got = {weight, update_w_flag, time_diff, ltp};
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset;
    step(1'b1, 1'b1, 1'b1);
    checks++;
    if (got !== {8'd128, 1'b0, 5'd0, 1'b0}) begin
      errors++; $display("FAIL reset_state got %h exp %h", got, {8'd128, 1'b0, 5'd0, 1'b0});
    end
    step(1'b0, 1'b1, 1'b0);
    checks++;
    if (got !== {8'd128, 1'b0, 5'd0, 1'b0}) begin
      errors++; $display("FAIL reset_spike_ignored got %h exp %h", got, {8'd128, 1'b0, 5'd0, 1'b0});
    end
  endtask

  task automatic test_ltp_basic;
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    idle(2);
    step(1'b0, 1'b1, 1'b0);
    checks++;
    if (got !== {8'd144, 1'b1, 5'd3, 1'b1}) begin
      errors++; $display("FAIL ltp_dt3 got %h exp %h", got, {8'd144, 1'b1, 5'd3, 1'b1});
    end
    idle(1);
    checks++;
    if (got !== {8'd144, 1'b0, 5'd3, 1'b1}) begin
      errors++; $display("FAIL ltp_flag_drop got %h exp %h", got, {8'd144, 1'b0, 5'd3, 1'b1});
    end
  endtask

  task automatic test_ltd_basic;
    logic [14:0] e;
`ifdef STDP_LTD_EN
    e = {8'd120, 1'b1, 5'd6, 1'b0};
`else
    e = {8'd128, 1'b0, 5'd0, 1'b0};
`endif
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    idle(5);
    step(1'b1, 1'b0, 1'b0);
    checks++;
    if (got !== e) begin
      errors++; $display("FAIL ltd_dt6 got %h exp %h", got, e);
    end
  endtask

  task automatic test_saturation;
    int ew;
    step(1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 11; i++) begin
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      ew = (WI + 16 * i > 255) ? 255 : WI + 16 * i;
      checks++;
      if (got !== {8'(ew), 1'b1, 5'd1, 1'b1}) begin
        errors++; $display("FAIL ltp_sat_pair%0d got %h exp %h", i, got, {8'(ew), 1'b1, 5'd1, 1'b1});
      end
      idle(WIN + 1);
    end
    for (int i = 1; i <= 17; i++) begin
      step(1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0);
`ifdef STDP_LTD_EN
      ew = (255 - 16 * i < 0) ? 0 : 255 - 16 * i;
      checks++;
      if (got !== {8'(ew), 1'b1, 5'd1, 1'b0}) begin
        errors++; $display("FAIL ltd_floor_pair%0d got %h exp %h", i, got, {8'(ew), 1'b1, 5'd1, 1'b0});
      end
`else
      checks++;
      if (got !== {8'd255, 1'b0, 5'd1, 1'b1}) begin
        errors++; $display("FAIL ltd_off_pair%0d got %h exp %h", i, got, {8'd255, 1'b0, 5'd1, 1'b1});
      end
`endif
      idle(WIN + 1);
    end
  endtask

  task automatic test_simultaneous;
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    checks++;
    if (got !== {8'd128, 1'b0, 5'd0, 1'b0}) begin
      errors++; $display("FAIL simul_no_update got %h exp %h", got, {8'd128, 1'b0, 5'd0, 1'b0});
    end
    idle(1);
    step(1'b0, 1'b1, 1'b0);
    checks++;
    if (got !== {8'd144, 1'b1, 5'd2, 1'b1}) begin
      errors++; $display("FAIL simul_then_post got %h exp %h", got, {8'd144, 1'b1, 5'd2, 1'b1});
    end
  endtask

  task automatic test_window;
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    idle(15);
    step(1'b0, 1'b1, 1'b0);
    checks++;
    if (got !== {8'd128, 1'b0, 5'd0, 1'b0}) begin
      errors++; $display("FAIL window_expired got %h exp %h", got, {8'd128, 1'b0, 5'd0, 1'b0});
    end
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    idle(14);
    step(1'b0, 1'b1, 1'b0);
    checks++;
    if (got !== {8'd130, 1'b1, 5'd15, 1'b1}) begin
      errors++; $display("FAIL window_edge got %h exp %h", got, {8'd130, 1'b1, 5'd15, 1'b1});
    end
  endtask

  task automatic test_reset_mid;
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    idle(1);
    step(1'b0, 1'b0, 1'b1);
    idle(1);
    step(1'b0, 1'b1, 1'b0);
    checks++;
    if (got !== {8'd128, 1'b0, 5'd0, 1'b0}) begin
      errors++; $display("FAIL reset_mid_window got %h exp %h", got, {8'd128, 1'b0, 5'd0, 1'b0});
    end
  endtask

  task automatic test_random;
    logic p, q, r;
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3000; i++) begin
      p = ($urandom_range(0, 5) == 0);
      q = ($urandom_range(0, 5) == 0);
      r = ($urandom_range(0, 399) == 0);
      step(p, q, r);
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL random_step%0d got %h exp %h", i, got, exp);
      end
    end
  endtask

  initial begin
    test_reset;
    test_ltp_basic;
    test_ltd_basic;
    test_saturation;
    test_simultaneous;
    test_window;
    test_reset_mid;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stdp_learn.md
STDP_LEARN -- requirements
Module: stdp_learn

Interface
REQ-001 SHALL have parameter WINDOW, default 15, meaning the largest spike-time difference in cycles that causes an update (legal range 1..30).
REQ-002 SHALL have parameter W_INIT, default 8'd128, meaning the weight value after reset.
REQ-003 SHALL have parameter A_LTP, default 8'd16, meaning the base potentiation step.
REQ-004 SHALL have parameter A_LTD, default 8'd16, meaning the base depression step.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port pre_spike, input, 1 bit: presynaptic LIF spike pulse, sampled every edge.
REQ-008 SHALL have port post_spike, input, 1 bit: postsynaptic LIF spike pulse, sampled every edge.
REQ-009 SHALL have port weight, output, 8 bits: current synaptic weight, registered.
REQ-010 SHALL have port update_w_flag, output, 1 bit: one-cycle pulse marking a weight change.
REQ-011 SHALL have port time_diff, output, 5 bits: dt of the most recent update, held between updates.
REQ-012 SHALL have port ltp, output, 1 bit: 1 if the most recent update was potentiation, 0 if it was depression, held between updates.

Function
REQ-013 SHALL keep a 5-bit pre timer and a 5-bit post timer, each with a valid bit.
- On the edge sampling a spike: timer <= 1, valid <= 1.
- Otherwise, while valid: timer increments by one per edge.
- When timer exceeds WINDOW: valid <= 0 and timer holds.
REQ-014 SHALL define dt as the value of the opposite timer on the edge that samples a spike, so spikes k cycles apart give dt = k.
REQ-015 SHALL potentiate on post_spike=1, pre_spike=0, pre valid: weight <= min(255, weight + (A_LTP >> (dt>>2))).
REQ-016 SHALL depress on pre_spike=1, post_spike=0, post valid: weight <= max(0, weight - (A_LTD >> (dt>>2))).
REQ-017 SHALL compute each step at 9-bit width and saturate to the 0..255 range, never wrapping.
REQ-018 SHALL apply nearest-neighbour pairing: a pairing clears the valid bit of the consumed opposite timer, so each spike pairs at most once; a repeated same-side spike reloads its own timer.
REQ-019 SHALL make no weight change when pre_spike and post_spike are sampled in the same cycle; both timers reload to 1.
REQ-020 SHALL make no weight change when the opposite timer is invalid or expired; the own timer still reloads.
REQ-021 SHALL have latency 1: weight, time_diff, ltp and update_w_flag=1 are all visible after the same edge that samples the spike.
REQ-022 SHALL drive update_w_flag=1 for exactly one cycle per update, including when saturation leaves the weight value unchanged.

Reset
REQ-023 SHALL, on rst=1 at a clock edge, set weight=W_INIT, update_w_flag=0, time_diff=0, ltp=0, both timers=0 and both valid bits=0.
REQ-024 SHALL give rst priority over spikes sampled on the same edge, and reset mid-window SHALL discard any pending pairing.

Configuration
REQ-025 SHALL use macro STDP_LTD_EN to select depression.
- Defined: REQ-016 depression is compiled in.
- Undefined: pre-after-post pairings cause no weight change and no flag, the post timer still runs, and ltp is constant 1 after the first update.

Verification (defaults, STDP_LTD_EN defined)
REQ-026 SHALL cover: pre at cycle 0, post at cycle 3 -> dt=3, weight 128->144, flag one cycle, time_diff=3, ltp=1.
REQ-027 SHALL cover: post at cycle 0, pre at cycle 6 -> step 16>>1=8, weight 128->120, time_diff=6, ltp=0; without STDP_LTD_EN -> weight stays 128, no flag.
REQ-028 SHALL cover: eleven consecutive pre-then-post pairs at dt=1 from 128 -> weight saturates at 255 and flag pulses every pairing; a mirrored LTD run -> weight floors at 0.
REQ-029 SHALL cover: pre and post in the same cycle -> weight unchanged, no flag; then a post 2 cycles later -> dt=2, weight 144.
REQ-030 SHALL cover: pre at 0, post at 16 -> no update (expired); pre at 0, post at 15 -> +2 (16>>3), weight 130.
REQ-031 SHALL cover: pre at 0, rst at 2, post at 4 -> weight=128, no flag, all timers invalid after reset.
